// File: rtl/spi_pkg.sv
// Shared types and helpers for the PL-side SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD
  } spi_state_t;

  // Mode 0 only: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int CS_MAX = 32;

  // Active-low chip-select vector for a target index; out-of-range selects
  // leave every line deasserted.
  function automatic logic [CS_MAX-1:0] cs_onehot_n(input int unsigned sel,
                                                    input int unsigned num_cs);
    logic [CS_MAX-1:0] v;
    v = '1;
    if (sel < num_cs && sel < CS_MAX) v[sel[4:0]] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK phase generator: counts CLK_DIV cycles per half-period and emits
// single-cycle rise/fall strobes for the FSM.
module spi_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk100,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic clr_hi_i,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;
  logic          tick;

  // Half-period counter; clear preloads the phase so the first strobe is
  // a fall when entering from SETUP (SCLK already high) or a rise from NEXT.
  always_comb begin
    tick  = en_i && (cnt_q == CW'(CLK_DIV - 1));
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (clr_i) begin
      cnt_d = '0;
      hi_d  = clr_hi_i;
    end else if (tick) begin
      cnt_d = '0;
      hi_d  = ~hi_q;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_stb_o = tick && !hi_q;
    fall_stb_o = tick && hi_q;
  end

  // Counter and phase registers.
  always_ff @(posedge clk100) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, with valid/ready word stream in and a
// one-word-per-word-sent response pulse out.
module spi_master
  import spi_pkg::*;
#(
  parameter  int CLK_DIV  = 8,
  parameter  int DATA_W   = 8,
  parameter  int NUM_CS   = 3,
  parameter  int CS_SETUP = 2,
  parameter  int CS_HOLD  = 2,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] csn_o,
  input  logic              miso_i
);

  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rxd_q, rxd_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUM_CS-1:0] csn_q, csn_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rdy_q, rdy_d;
  logic              rxv_q, rxv_d;
  logic              busy_q;
  logic              rise_stb, fall_stb, accept;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk100     (clk100),
    .rst        (rst),
    .en_i       (state_q == SHIFT),
    .clr_i      (state_q != SHIFT),
    .clr_hi_i   (state_q != NEXT),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Next-state and registered-output logic. One shift register carries TX
  // out of the top and collects MISO into the bottom.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rxd_d   = rxd_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    csn_d   = csn_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rdy_d   = 1'b0;
    rxv_d   = 1'b0;
    accept  = tx_valid_i && rdy_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d = SETUP;
          sh_d    = tx_data_i;
          mosi_d  = tx_data_i[DATA_W-1];
          last_d  = tx_last_i;
          csn_d   = NUM_CS'(cs_onehot_n(32'(cs_sel_i), NUM_CS));
          cnt_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == TW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          sclk_d  = ~SPI_CPOL;
          sh_d    = {sh_q[DATA_W-2:0], miso_i};
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (rise_stb) begin
          sclk_d = ~SPI_CPOL;
          sh_d   = {sh_q[DATA_W-2:0], miso_i};
        end
        if (fall_stb) begin
          sclk_d = SPI_CPOL;
          if (bit_q == BW'(DATA_W - 1)) begin
            rxd_d  = sh_q;
            rxv_d  = 1'b1;
            mosi_d = 1'b0;
            cnt_d  = '0;
            if (last_q) begin
              state_d = HOLD;
            end else begin
              state_d = NEXT;
              rdy_d   = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = sh_q[DATA_W-1];
          end
        end
      end
      NEXT: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d = SHIFT;
          sh_d    = tx_data_i;
          mosi_d  = tx_data_i[DATA_W-1];
          last_d  = tx_last_i;
          bit_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == TW'(CS_HOLD - 1)) begin
          state_d = IDLE;
          csn_d   = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rxd_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      csn_q   <= '1;
      last_q  <= 1'b0;
      sclk_q  <= SPI_CPOL;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rxv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rxd_q   <= rxd_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      csn_q   <= csn_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      rxv_q   <= rxv_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign tx_ready_o = rdy_q;
  assign rx_data_o  = rxd_q;
  assign rx_valid_o = rxv_q;
  assign busy_o     = busy_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign csn_o      = csn_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: a behavioural mode-0 slave and a
// transaction/timing reference built from the frame timing rules.
module tb_spi_master;

  localparam int D = 8, W = 8, N = 3, SU = 2, HO = 2;

  logic         clk100 = 1'b0;
  logic         rst;
  logic [W-1:0] tx_data_i;
  logic         tx_last_i;
  logic [1:0]   cs_sel_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o;
  logic         busy_o;
  logic         sclk_o;
  logic         mosi_o;
  logic [N-1:0] csn_o;
  logic         miso_i;

  always #5 clk100 = ~clk100;

  spi_master #(.CLK_DIV(D), .DATA_W(W), .NUM_CS(N), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
    .clk100(clk100), .rst(rst), .tx_data_i(tx_data_i), .tx_last_i(tx_last_i),
    .cs_sel_i(cs_sel_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .csn_o(csn_o), .miso_i(miso_i)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / slave state
  int           mon_cyc = 0;
  int           rises, first_rise, csn_falls, csn_bad, csn_low_first, csn_hi;
  int           rdy_busy, rdy_sclk, rdy_ret, sbit;
  int           acc_q[$], rxc_q[$];
  logic [W-1:0] rx_q[$], sq[$];
  bit           mosi_q[$];
  bit           loop_m = 1'b0;
  logic [N-1:0] exp_csn = '1;
  logic         sclk_prev = 1'b0;
  logic [N-1:0] csn_prev = '1;
  logic [W-1:0] tw[4], sw[4];

  // Observe outputs mid-cycle, log events, and play the slave on MISO.
  always @(negedge clk100) begin
    logic [W-1:0] cur;
    mon_cyc++;
    if (!rst) begin
      if (tx_valid_i && tx_ready_o) acc_q.push_back(mon_cyc);
      if (sclk_o && !sclk_prev) begin
        rises++;
        if (first_rise < 0) first_rise = mon_cyc;
        mosi_q.push_back(mosi_o);
      end
      if (!sclk_o && sclk_prev) begin
        sbit++;
        if (sbit == W) begin
          sbit = 0;
          if (sq.size() > 0) void'(sq.pop_front());
        end
      end
      if (rx_valid_o) begin
        rx_q.push_back(rx_data_o);
        rxc_q.push_back(mon_cyc);
      end
      if (csn_o != '1) begin
        if (csn_prev == '1) csn_falls++;
        if (csn_low_first < 0) csn_low_first = mon_cyc;
        if (csn_o != exp_csn) csn_bad++;
      end else if (csn_prev != '1) begin
        csn_hi = mon_cyc;
      end
      if (tx_ready_o && busy_o) rdy_busy++;
      if (tx_ready_o && sclk_o) rdy_sclk++;
      if (tx_ready_o && csn_hi >= 0 && rdy_ret < 0) rdy_ret = mon_cyc;
    end
    if (loop_m) miso_i = mosi_o;
    else if (sq.size() > 0) begin
      cur = sq[0];
      miso_i = cur[W-1-sbit];
    end else miso_i = 1'b0;
    sclk_prev = sclk_o;
    csn_prev  = csn_o;
  end

  task automatic clear_mon(input int sel, input bit loop);
    rises = 0; first_rise = -1; csn_falls = 0; csn_bad = 0; csn_low_first = -1;
    csn_hi = -1; rdy_busy = 0; rdy_sclk = 0; rdy_ret = -1; sbit = 0;
    acc_q.delete(); rxc_q.delete(); rx_q.delete(); sq.delete(); mosi_q.delete();
    loop_m  = loop;
    exp_csn = (sel < N) ? N'(~(32'd1 << sel)) : '1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit last, input int sel);
    bit ok = 1'b0;
    tx_data_i = d; tx_last_i = last; cs_sel_i = 2'(sel); tx_valid_i = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk100);
      if (tx_ready_o) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk100); #1;
  endtask

  task automatic wait_rx(input int k);
    for (int t = 0; t < 5000 && rx_q.size() < k; t++) @(posedge clk100);
    if (rx_q.size() < k) chk("rx_timeout", rx_q.size(), k);
  endtask

  task automatic run_frame(input int n, input int sel, input bit loop, input int gap, input bit hold);
    logic [W-1:0] gw, expw;
    int nb;
    clear_mon(sel, loop);
    if (!loop) for (int i = 0; i < n; i++) sq.push_back(sw[i]);
    for (int i = 0; i < n; i++) begin
      push_word(tw[i], i == n - 1, (i == 0) ? sel : int'($urandom_range(0, 3)));
      if (i < n - 1 && !hold) begin
        tx_valid_i = 1'b0;
        wait_rx(i + 1);
        repeat (gap) @(posedge clk100);
        #1;
      end
    end
    tx_valid_i = 1'b0;
    for (int t = 0; t < 5000 && busy_o; t++) @(negedge clk100);
    if (busy_o) chk("busy_timeout", busy_o, 0);
    repeat (4) @(posedge clk100);
    #1;
    chk("n_acc", acc_q.size(), n);
    chk("n_rx", rx_q.size(), n);
    chk("rises", rises, n * W);
    chk("sclk_in_next", rdy_sclk, 0);
    if (acc_q.size() == n && rx_q.size() == n) begin
      for (int k = 0; k < n; k++) begin
        expw = loop ? tw[k] : sw[k];
        chk($sformatf("rx_data%0d", k), rx_q[k], expw);
        chk($sformatf("rx_cyc%0d", k), rxc_q[k] - acc_q[k],
            (k == 0) ? (1 + SU + (2 * W - 1) * D) : (1 + 2 * W * D));
      end
      chk("first_rise", first_rise - acc_q[0], 1 + SU);
      if (sel < N) begin
        chk("csn_low_at", csn_low_first - acc_q[0], 1);
        chk("csn_high_at", csn_hi - rxc_q[n-1], HO);
        chk("ready_return", rdy_ret - csn_hi, 1);
      end
    end
    nb = mosi_q.size();
    if (nb == n * W) begin
      for (int k = 0; k < n; k++) begin
        gw = '0;
        for (int b = 0; b < W; b++) gw = {gw[W-2:0], mosi_q[k * W + b]};
        chk($sformatf("mosi%0d", k), gw, tw[k]);
      end
    end
    chk("csn_falls", csn_falls, (sel < N) ? 1 : 0);
    chk("csn_wrong_line", csn_bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_valid_i = 1'b0; tx_data_i = '0; tx_last_i = 1'b0; cs_sel_i = '0;
    clear_mon(0, 1);
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    chk("rst_ready", tx_ready_o, 0);
    chk("rst_csn", csn_o, 3'b111);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_mosi", mosi_o, 0);
    chk("rst_rxv", rx_valid_o, 0);
    chk("rst_rxd", rx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk100); #1 rst = 1'b0;
    @(posedge clk100); @(negedge clk100);
    chk("post_rst_ready", tx_ready_o, 1);
    @(posedge clk100); #1;

    // Single-word loopback 0xA5 on CS0
    tw[0] = 8'hA5;
    run_frame(1, 0, 1'b1, 0, 1'b0);

    // Three-word frame, valid held high
    tw[0] = 8'h01; tw[1] = 8'h80; tw[2] = 8'hFF;
    run_frame(3, 0, 1'b1, 0, 1'b1);
    chk("held_next_cycles", rdy_busy, 2);

    // 50-cycle stall in NEXT against the slave
    tw[0] = W'($urandom); tw[1] = W'($urandom);
    sw[0] = W'($urandom); sw[1] = W'($urandom);
    run_frame(2, 0, 1'b0, 50, 1'b0);
    chk("stall_next_cycles", rdy_busy, 52);

    // Slave on CS1
    for (int i = 0; i < 2; i++) begin tw[i] = W'($urandom); sw[i] = W'($urandom); end
    run_frame(2, 1, 1'b0, 0, 1'b0);

    // Out-of-range select: no CS activity but frame still runs
    tw[0] = W'($urandom); sw[0] = W'($urandom);
    run_frame(1, 3, 1'b0, 0, 1'b0);

    // Reset at cycle 60 of a frame
    clear_mon(0, 1);
    push_word(W'($urandom), 1'b1, 0);
    tx_valid_i = 1'b0;
    repeat (59) @(posedge clk100);
    #1 rst = 1'b1;
    @(posedge clk100); #1 rst = 1'b0;
    @(negedge clk100);
    chk("midrst_csn", csn_o, 3'b111);
    chk("midrst_sclk", sclk_o, 0);
    chk("midrst_busy", busy_o, 0);
    repeat (200) @(posedge clk100);
    #1;
    chk("midrst_no_rx", rx_q.size(), 0);
    tw[0] = W'($urandom);
    run_frame(1, 2, 1'b1, 0, 1'b0);

    // Randomized frames
    repeat (6) begin
      int n, sel, gap;
      bit hold;
      n = int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 12));
      hold = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin tw[i] = W'($urandom); sw[i] = W'($urandom); end
      run_frame(n, sel, 1'b0, gap, hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- PL-side SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Drives SCLK, MOSI and NUM_CS active-low chip selects, and samples MISO.
- Fabric logic issues words over a valid/ready byte stream and receives one word back for every word sent.
- It sits beside the PS SPI path. It drives the existing `spi` responder directly in loopback tests, and external slaves through the board headers.

Parameters:
- CLK_DIV, 8: clk100 cycles per SCLK half-period. Must be ≥2. Default SCLK is 6.25 MHz.
- DATA_W, 8: bits per word.
- NUM_CS, 3: number of chip selects.
- CS_SETUP, 2: clk100 cycles from csn falling to the first SCLK rising edge. Must be ≥1.
- CS_HOLD, 2: clk100 cycles from the final SCLK falling edge to csn rising. Must be ≥1.

Ports:
- clk100  in  1  System clock. This is the only clock.
- rst  in  1  Synchronous reset, active-high.
- tx_data_i  in  DATA_W  Word to transmit.
- tx_last_i  in  1  Deassert CS after this word.
- cs_sel_i  in  $clog2(NUM_CS)  Target slave. Sampled only on the first word of a frame.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  Master accepts a word this cycle.
- rx_data_o  out  DATA_W  Word received on MISO.
- rx_valid_o  out  1  One-cycle pulse. No backpressure.
- busy_o  out  1  A frame is in progress (any state other than IDLE).
- sclk_o  out  1  SPI clock. Idles low.
- mosi_o  out  1  Master out.
- csn_o  out  NUM_CS  Chip selects, active-low.
- miso_i  in  1  Master in.

Behaviour:
- Reset values: tx_ready_o=0 during rst and 1 in the cycle after, rx_data_o=0, rx_valid_o=0, busy_o=0, sclk_o=0, mosi_o=0, csn_o=all ones.
- All outputs are registered.
- A word is accepted when tx_valid_i && tx_ready_o. tx_ready_o is high only in IDLE and NEXT.
- State machine:
  - IDLE → SETUP on accept. Capture data, cs_sel_i and last. Next cycle: csn_o[cs_sel] goes low and mosi_o is driven with MSB.
  - SETUP: wait CS_SETUP cycles, then → SHIFT.
  - SHIFT: each bit takes 2*CLK_DIV cycles. sclk_o rises and MISO is sampled into the shift register in the same cycle. CLK_DIV cycles later sclk_o falls and mosi_o advances to the next bit.
  - On the final (DATA_W-th) falling edge, the received word is loaded into rx_data_o and rx_valid_o pulses in that same cycle.
  - From the final falling edge: if last → HOLD, otherwise → NEXT.
  - NEXT: tx_ready_o=1, csn stays low, sclk_o stays low.
    - On accept: load the new word, mosi_o gets its MSB the next cycle, and the first rising edge follows CLK_DIV cycles later → SHIFT.
    - Stalls indefinitely if tx_valid_i stays low.
  - HOLD: after CS_HOLD cycles, csn_o goes all ones → IDLE.
  - tx_ready_o returns the cycle after csn rises, so CS is guaranteed high for ≥1 cycle between frames.
- Frame timing with defaults (accept at cycle 0):
  - csn low at cycle 1.
  - Rising edges at 3 + 16k, for k = 0..7.
  - Final fall at cycle 123, with rx_valid_o in the same cycle.
  - csn high at cycle 125.
  - tx_ready_o high at cycle 126.
- cs_sel_i ≥ NUM_CS: the frame runs with all csn_o held high. There is no error flag.
- miso_i is sampled unsynchronised at the rising-edge cycle. The slave must drive MISO ≥1 cycle before that edge, which mode 0 guarantees with CLK_DIV ≥ 2.
- rst mid-frame: next cycle, sclk_o=0 and csn_o=all ones. No rx_valid_o for the partial word. The state returns to IDLE.
- tx_last_i and cs_sel_i in NEXT: tx_last_i is honoured per word. cs_sel_i is ignored.

Decomposition:
- spi_pkg holds:
  - the state enum typedef spi_state_t (IDLE, SETUP, SHIFT, NEXT, HOLD);
  - the constants SPI_CPOL=0 and SPI_CPHA=0;
  - the function cs_onehot_n() that maps cs_sel to a csn vector.
- Sub-module spi_clk_gen: a counter with enable and clear that emits single-cycle rise_stb/fall_stb every CLK_DIV cycles. The FSM consumes these strobes.

Test Plan:
- Single-word loopback (miso_i tied to mosi_o), tx=0xA5, last=1, cs_sel=0 → csn_o=3'b110 cycles 1–124; mosi_o bit pattern 1,0,1,0,0,1,0,1; 8 rising edges; rx_data_o=0xA5 with rx_valid_o at cycle 123; csn_o=3'b111 at 125.
- Three-word frame 0x01, 0x80, 0xFF, last only on the third, tx_valid_i held high → csn stays low throughout, 24 SCLK pulses, three rx_valid_o pulses, tx_ready_o high exactly at the NEXT cycles.
- NEXT stall: drop tx_valid_i for 50 cycles after word 1 → sclk_o=0 and csn low throughout the gap; word 2 resumes with correct data.
- Against the `spi` responder with cs_sel=1 → only csn_o[1] toggles; MISO bytes from the responder are captured exactly.
- rst asserted at cycle 60 of a frame → cycle 61: csn_o=3'b111, sclk_o=0, busy_o=0, no rx_valid_o; the next frame completes normally.
- cs_sel=3 with NUM_CS=3 → SCLK and MOSI toggle, csn_o stays 3'b111, rx_valid_o still pulses.
